// File: rtl/problema_5_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands; the slave (adder) returns registered results.
interface problema_5_if #(
    parameter int unsigned WIDTH = 2
) ();
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;

    modport master (
        output A, B, cin, in_valid,
        input  sum, cout, out_valid
    );

    modport slave (
        input  A, B, cin, in_valid,
        output sum, cout, out_valid
    );
endinterface

// File: rtl/problema_5.sv
// Registered WIDTH-bit ripple-carry adder with carry-in/out, one-cycle latency.
// Results hold while no valid operands arrive; out_valid pulses per accepted input.
module problema_5 #(
    parameter int unsigned WIDTH = 2
) (
    input logic        clk,
    input logic        rst_n,
    problema_5_if.slave bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] add_sum;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    // Chain of full-adder cells, c_0 taken from cin
    always_comb begin
        carry    = '0;
        add_sum  = '0;
        carry[0] = bus.cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            add_sum[i]   = bus.A[i] ^ bus.B[i] ^ carry[i];
            carry[i + 1] = (bus.A[i] & bus.B[i]) | (carry[i] & (bus.A[i] ^ bus.B[i]));
        end
    end

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            sum_d  = add_sum;
            cout_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_problema_5.sv
// Self-checking bench for problema_5: corner-case table, exhaustive sweep,
// hand-written hold/reset sequences and a randomized run against an arithmetic model.
module tb_problema_5;
    localparam int unsigned WIDTH = 2;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       c;
        logic [1:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Reference model state: what the outputs must read after each edge
    logic [1:0] m_sum;
    logic       m_cout;
    logic       m_valid;

    problema_5_if #(.WIDTH(WIDTH)) bus ();

    problema_5 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] s, input logic c, input logic v);
        total++;
        if (bus.sum !== s || bus.cout !== c || bus.out_valid !== v) begin
            bad++;
            $display("FAIL %s: got sum=%0d cout=%0d out_valid=%0d, want sum=%0d cout=%0d out_valid=%0d",
                     name, bus.sum, bus.cout, bus.out_valid, s, c, v);
        end
    endtask

    // Drive one cycle of inputs, clock it, and advance the model
    task automatic step(input logic [1:0] a, input logic [1:0] b, input logic c,
                        input logic v, input logic r);
        int tot;
        bus.A        = a;
        bus.B        = b;
        bus.cin      = c;
        bus.in_valid = v;
        rst_n        = r;
        @(posedge clk);
        #1;
        if (!r) begin
            m_sum   = 2'd0;
            m_cout  = 1'b0;
            m_valid = 1'b0;
        end else begin
            if (v) begin
                tot    = int'(a) + int'(b) + int'(c);
                m_sum  = 2'(tot % 4);
                m_cout = (tot >= 4);
            end
            m_valid = v;
        end
    endtask

    vec_t vecs[12];

    initial begin
        total = 0;
        bad   = 0;
        m_sum = 2'd0; m_cout = 1'b0; m_valid = 1'b0;
        bus.A = '0; bus.B = '0; bus.cin = 1'b0; bus.in_valid = 1'b0;
        rst_n = 1'b0;

        vecs[0]  = '{2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{2'd1, 2'd1, 1'b0, 2'd2, 1'b0};
        vecs[2]  = '{2'd2, 2'd1, 1'b0, 2'd3, 1'b0};
        vecs[3]  = '{2'd2, 2'd2, 1'b0, 2'd0, 1'b1};
        vecs[4]  = '{2'd3, 2'd2, 1'b0, 2'd1, 1'b1};
        vecs[5]  = '{2'd3, 2'd3, 1'b0, 2'd2, 1'b1};
        vecs[6]  = '{2'd0, 2'd0, 1'b1, 2'd1, 1'b0};
        vecs[7]  = '{2'd1, 2'd1, 1'b1, 2'd3, 1'b0};
        vecs[8]  = '{2'd2, 2'd1, 1'b1, 2'd0, 1'b1};
        vecs[9]  = '{2'd1, 2'd2, 1'b1, 2'd0, 1'b1};
        vecs[10] = '{2'd2, 2'd2, 1'b1, 2'd1, 1'b1};
        vecs[11] = '{2'd3, 2'd3, 1'b1, 2'd3, 1'b1};

        // Reset dominates valid operands
        for (int i = 0; i < 2; i++) begin
            step(2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
            check("reset", 2'd0, 1'b0, 1'b0);
        end

        // Corner table, back-to-back
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1, 1'b1);
            check($sformatf("corner%0d", i), vecs[i].exp_sum, vecs[i].exp_cout, 1'b1);
        end

        // Exhaustive sweep streamed back-to-back
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) begin
                    step(2'(a), 2'(b), 1'(c), 1'b1, 1'b1);
                    check($sformatf("sweep_%0d_%0d_%0d", a, b, c), 2'((a + b + c) % 4),
                          (a + b + c) >= 4, 1'b1);
                end

        // Hold when in_valid drops
        step(2'd3, 2'd2, 1'b1, 1'b1, 1'b1);
        check("hold_load", 2'd2, 1'b1, 1'b1);
        step(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("hold_1", 2'd2, 1'b1, 1'b0);
        step(2'd1, 2'd1, 1'b1, 1'b0, 1'b1);
        check("hold_2", 2'd2, 1'b1, 1'b0);

        // Reset mid-stream, then resume
        step(2'd3, 2'd3, 1'b1, 1'b1, 1'b1);
        check("mid_load", 2'd3, 1'b1, 1'b1);
        step(2'd2, 2'd1, 1'b0, 1'b1, 1'b0);
        check("mid_reset", 2'd0, 1'b0, 1'b0);
        step(2'd1, 2'd0, 1'b0, 1'b1, 1'b1);
        check("mid_resume", 2'd1, 1'b0, 1'b1);

        // Randomized traffic with sporadic idle cycles and resets
        for (int i = 0; i < 300; i++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 24) != 0);
            check($sformatf("rand%0d", i), m_sum, m_cout, m_valid);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
